bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 96 +++++++++
 tb/tb_bus_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter.
// A contended grant is held for at most MAX_HOLD cycles before handover.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic M0_req,
  input  logic M1_req,
  output logic M0_grant,
  output logic M1_grant,
  output logic M_sel,
  output logic bus_busy
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  state_t     state, state_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic       last, last_nx;

  always_comb begin
    state_nx = state;
    hold_nx  = '0;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        if (M0_req && M1_req)
          state_nx = last ? GRANT0 : GRANT1;
        else if (M0_req)
          state_nx = GRANT0;
        else if (M1_req)
          state_nx = GRANT1;
      end
      GRANT0: begin
        if (!M0_req)
          state_nx = M1_req ? GRANT1 : IDLE;
        else if (M1_req) begin
          if (hold_cnt == HOLD_MAX)
            state_nx = GRANT1;
          else
            hold_nx = hold_cnt + 8'd1;
        end
      end
      GRANT1: begin
        if (!M1_req)
          state_nx = M0_req ? GRANT0 : IDLE;
        else if (M0_req) begin
          if (hold_cnt == HOLD_MAX)
            state_nx = GRANT0;
          else
            hold_nx = hold_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == GRANT0 && state != GRANT0)
      last_nx = 1'b0;
    if (state_nx == GRANT1 && state != GRANT1)
      last_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      last     <= last_nx;
    end
  end

  // Outputs come straight from flops fed by the next-state decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      M0_grant <= 1'b0;
      M1_grant <= 1'b0;
      M_sel    <= 1'b0;
      bus_busy <= 1'b0;
    end else begin
      M0_grant <= (state_nx == GRANT0);
      M1_grant <= (state_nx == GRANT1);
      M_sel    <= (state_nx == GRANT1);
      bus_busy <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter.
// Outputs are checked against an owner/wait-count reference model.
module tb_bus_arbiter;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic M0_req, M1_req;
  logic M0_grant, M1_grant, M_sel, bus_busy;

  int errors = 0;
  int checks = 0;

  // Model: owner -1 = bus free, wait = consecutive contended cycles.
  int m_own, m_wait, m_last;

  bus_arbiter #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .M0_req   (M0_req),
    .M1_req   (M1_req),
    .M0_grant (M0_grant),
    .M1_grant (M1_grant),
    .M_sel    (M_sel),
    .bus_busy (bus_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_wait = 0;
    m_last = 1;
  endtask

  task automatic model_step(input logic r0, input logic r1);
    int want_me, want_other, nxt;
    nxt = m_own;
    if (m_own < 0) begin
      if (r0 && r1) nxt = 1 - m_last;
      else if (r0)  nxt = 0;
      else if (r1)  nxt = 1;
      m_wait = 0;
    end else begin
      want_me    = (m_own == 0) ? int'(r0) : int'(r1);
      want_other = (m_own == 0) ? int'(r1) : int'(r0);
      if (want_me == 0) begin
        nxt    = want_other ? 1 - m_own : -1;
        m_wait = 0;
      end else if (want_other != 0) begin
        m_wait++;
        if (m_wait >= MH) begin
          nxt    = 1 - m_own;
          m_wait = 0;
        end
      end else begin
        m_wait = 0;
      end
    end
    if (nxt >= 0 && nxt != m_own) m_last = nxt;
    m_own = nxt;
  endtask

  function automatic logic [3:0] model_out();
    case (m_own)
      0:       return 4'b1001;
      1:       return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] dut_out();
    return {M0_grant, M1_grant, M_sel, bus_busy};
  endfunction

  task automatic tick(input string tag);
    @(posedge clk);
    if (reset_n) model_step(M0_req, M1_req);
    @(negedge clk);
    chk(tag, dut_out(), model_out());
    chk("mutex", {3'b0, M0_grant & M1_grant}, 4'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    M0_req  = 1'b1;
    M1_req  = 1'b1;
    model_reset();
    #2;
    chk("reset", dut_out(), 4'b0000);
    #15;
    reset_n = 1'b1;
    tick("rst_rel");
    chk("rst_rel_m0", dut_out(), 4'b1001);

    // M0 holds while M1 waits; 4 contended cycles then handover
    for (int i = 0; i < MH - 1; i++) begin
      tick("hold");
      chk("hold_g0", dut_out(), 4'b1001);
    end
    tick("force");
    chk("force_ho", dut_out(), 4'b0111);

    M0_req = 1'b0;
    M1_req = 1'b0;
    tick("to_idle");
    chk("idle", dut_out(), 4'b0000);

    M1_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("single");
      chk("single_m1", dut_out(), 4'b0111);
    end
    M1_req = 1'b0;
    tick("single_end");
    chk("single_idle", dut_out(), 4'b0000);

    M0_req = 1'b1;
    tick("m0_once");
    chk("m0_once_g", dut_out(), 4'b1001);
    M0_req = 1'b0;
    tick("m0_drop");
    chk("m0_drop_idle", dut_out(), 4'b0000);
    M0_req = 1'b1;
    M1_req = 1'b1;
    tick("rr");
    chk("rr_m1", dut_out(), 4'b0111);

    M1_req = 1'b0;
    tick("to_g0");
    chk("to_g0_g", dut_out(), 4'b1001);
    M0_req = 1'b0;
    M1_req = 1'b1;
    tick("rel");
    chk("rel_ho", dut_out(), 4'b0111);

    // asynchronous reset in the middle of a GRANT1 cycle
    @(posedge clk);
    model_step(M0_req, M1_req);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst", dut_out(), 4'b0000);
    @(negedge clk);
    chk("mid_rst_hold", dut_out(), 4'b0000);
    reset_n = 1'b1;
    M0_req  = 1'b1;
    M1_req  = 1'b0;
    tick("rst_g0");
    chk("rst_g0_g", dut_out(), 4'b1001);

    // random traffic, requests tend to persist
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) M0_req = 1'($urandom);
      if ($urandom_range(3) == 0) M1_req = 1'($urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
